// File: rtl/sc_statemachinepiece_pkg.sv
// sc_statemachinepiece_pkg: state, shift and action encodings shared by the piece controller
package sc_statemachinepiece_pkg;

   typedef enum logic [3:0] {
      ST_RESET  = 4'd0,
      ST_START  = 4'd1,
      ST_IDLE   = 4'd2,
      ST_INIT   = 4'd3,
      ST_CHECK  = 4'd4,
      ST_DOWN   = 4'd5,
      ST_LEFT   = 4'd6,
      ST_RIGHT  = 4'd7,
      ST_ROTATE = 4'd8,
      ST_HOLD   = 4'd9,
      ST_LOCK   = 4'd10
   } state_t;

   typedef enum logic [1:0] {
      ACT_DOWN   = 2'd0,
      ACT_LEFT   = 2'd1,
      ACT_RIGHT  = 2'd2,
      ACT_ROTATE = 2'd3
   } action_t;

   localparam logic [1:0] SHIFT_LEFT  = 2'b01;
   localparam logic [1:0] SHIFT_RIGHT = 2'b10;
   localparam logic [1:0] SHIFT_HOLD  = 2'b11;

   function automatic action_t act_of(state_t s);
      return s == ST_LEFT ? ACT_LEFT : s == ST_RIGHT ? ACT_RIGHT : s == ST_ROTATE ? ACT_ROTATE : ACT_DOWN;
   endfunction

   function automatic state_t act_state(action_t a);
      return a == ACT_LEFT ? ST_LEFT : a == ACT_RIGHT ? ST_RIGHT : a == ACT_ROTATE ? ST_ROTATE : ST_DOWN;
   endfunction

endpackage

// File: rtl/sc_statemachinepiece_if.sv
// sc_statemachinepiece_if: button/collision inputs and piece-register commands of the controller
interface sc_statemachinepiece_if;

   logic       SC_STATEMACHINEPIECE_startButton_InLow;
   logic       SC_STATEMACHINEPIECE_downButton_InLow;
   logic       SC_STATEMACHINEPIECE_leftButton_InLow;
   logic       SC_STATEMACHINEPIECE_rightButton_InLow;
   logic       SC_STATEMACHINEPIECE_rotateButton_InLow;
   logic       SC_STATEMACHINEPIECE_bottomside_InLow;
   logic       SC_STATEMACHINEPIECE_leftside_InLow;
   logic       SC_STATEMACHINEPIECE_rightside_InLow;
   logic       SC_STATEMACHINEPIECE_rotateblock_InLow;
   logic       SC_STATEMACHINEPIECE_clear_OutLow;
   logic       SC_STATEMACHINEPIECE_load0_OutLow;
   logic       SC_STATEMACHINEPIECE_load1_OutLow;
   logic [1:0] SC_STATEMACHINEPIECE_shiftselection_Out;
   logic       SC_STATEMACHINEPIECE_rotate_OutLow;

   modport master (
      input  SC_STATEMACHINEPIECE_startButton_InLow,
      input  SC_STATEMACHINEPIECE_downButton_InLow,
      input  SC_STATEMACHINEPIECE_leftButton_InLow,
      input  SC_STATEMACHINEPIECE_rightButton_InLow,
      input  SC_STATEMACHINEPIECE_rotateButton_InLow,
      input  SC_STATEMACHINEPIECE_bottomside_InLow,
      input  SC_STATEMACHINEPIECE_leftside_InLow,
      input  SC_STATEMACHINEPIECE_rightside_InLow,
      input  SC_STATEMACHINEPIECE_rotateblock_InLow,
      output SC_STATEMACHINEPIECE_clear_OutLow,
      output SC_STATEMACHINEPIECE_load0_OutLow,
      output SC_STATEMACHINEPIECE_load1_OutLow,
      output SC_STATEMACHINEPIECE_shiftselection_Out,
      output SC_STATEMACHINEPIECE_rotate_OutLow
   );

   modport slave (
      output SC_STATEMACHINEPIECE_startButton_InLow,
      output SC_STATEMACHINEPIECE_downButton_InLow,
      output SC_STATEMACHINEPIECE_leftButton_InLow,
      output SC_STATEMACHINEPIECE_rightButton_InLow,
      output SC_STATEMACHINEPIECE_rotateButton_InLow,
      output SC_STATEMACHINEPIECE_bottomside_InLow,
      output SC_STATEMACHINEPIECE_leftside_InLow,
      output SC_STATEMACHINEPIECE_rightside_InLow,
      output SC_STATEMACHINEPIECE_rotateblock_InLow,
      input  SC_STATEMACHINEPIECE_clear_OutLow,
      input  SC_STATEMACHINEPIECE_load0_OutLow,
      input  SC_STATEMACHINEPIECE_load1_OutLow,
      input  SC_STATEMACHINEPIECE_shiftselection_Out,
      input  SC_STATEMACHINEPIECE_rotate_OutLow
   );

endinterface

// File: rtl/sc_statemachinepiece_tickcounter.sv
// sc_tickcounter: wrapping 0..limit-1 counter with clear priority and a wrap pulse
module sc_tickcounter #(
   parameter int CNT_WIDTH = 25
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 en,
   input  logic [CNT_WIDTH-1:0] limit,
   output logic                 wrap
);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   // wrap ignores clr so a consumer may derive clr from wrap without a loop
   assign wrap = en && cnt_q == limit - CNT_WIDTH'(1);

   // next count: clear wins, then wrap to zero, else increment while enabled
   always_comb cnt_d = clr ? '0 : wrap ? '0 : en ? cnt_q + CNT_WIDTH'(1) : cnt_q;

   // count register
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;

endmodule

// File: rtl/sc_statemachinepiece.sv
// sc_statemachinepiece: falling-block piece controller with gravity, auto-repeat and collision gating
module sc_statemachinepiece
   import sc_statemachinepiece_pkg::*;
#(
   parameter int GRAVITY_TICKS = 25000000,
   parameter int REPEAT_DELAY  = 12500000,
   parameter int REPEAT_RATE   = 2500000,
   parameter int CNT_WIDTH     = 25
) (
   input logic                    SC_STATEMACHINEPIECE_CLOCK_50,
   input logic                    SC_STATEMACHINEPIECE_RESET_InHigh,
   sc_statemachinepiece_if.master bus
);

   localparam logic [CNT_WIDTH-1:0] GRAV_LIM = CNT_WIDTH'(GRAVITY_TICKS);
   localparam logic [CNT_WIDTH-1:0] DLY_LIM  = CNT_WIDTH'(REPEAT_DELAY);
   localparam logic [CNT_WIDTH-1:0] RATE_LIM = CNT_WIDTH'(REPEAT_RATE);

   state_t  state_q, state_d, grav_st;
   action_t act_q, act_d;
   logic    pend_q, pend_d, first_q, first_d;
   logic    rep_clr, rep_ok, grav_wrap, rep_wrap, all_high, timers_off;
   logic    start_n, down_n, left_n, right_n, rotate_n, bottom, lside, rside, rblock;

   assign start_n  = bus.SC_STATEMACHINEPIECE_startButton_InLow;
   assign down_n   = bus.SC_STATEMACHINEPIECE_downButton_InLow;
   assign left_n   = bus.SC_STATEMACHINEPIECE_leftButton_InLow;
   assign right_n  = bus.SC_STATEMACHINEPIECE_rightButton_InLow;
   assign rotate_n = bus.SC_STATEMACHINEPIECE_rotateButton_InLow;
   assign bottom   = bus.SC_STATEMACHINEPIECE_bottomside_InLow;
   assign lside    = bus.SC_STATEMACHINEPIECE_leftside_InLow;
   assign rside    = bus.SC_STATEMACHINEPIECE_rightside_InLow;
   assign rblock   = bus.SC_STATEMACHINEPIECE_rotateblock_InLow;

   assign all_high   = &{start_n, down_n, left_n, right_n, rotate_n};
   assign grav_st    = bottom ? ST_DOWN : ST_LOCK;
   assign timers_off = state_q inside {ST_RESET, ST_START, ST_IDLE, ST_INIT};

   // the remembered action may repeat only while its own button is held and its side is free
   always_comb
      rep_ok = act_q == ACT_DOWN  ? (!down_n && bottom) :
               act_q == ACT_LEFT  ? (!left_n && lside)  :
               act_q == ACT_RIGHT ? (!right_n && rside) : 1'b0;

   // next state, action/first-repeat bookkeeping and gravity pending flag
   always_comb begin
      state_d = state_q;
      act_d   = act_q;
      first_d = first_q;
      rep_clr = 1'b0;
      case (state_q)
         ST_RESET:  state_d = ST_START;
         ST_START:  state_d = ST_IDLE;
         ST_IDLE:   state_d = start_n ? ST_IDLE : ST_INIT;
         ST_INIT:   state_d = ST_CHECK;
         ST_CHECK: begin
            if (!start_n)                state_d = ST_INIT;
            else if (pend_q)             state_d = grav_st;
            else if (!down_n && bottom)  state_d = ST_DOWN;
            else if (!left_n && lside)   state_d = ST_LEFT;
            else if (!right_n && rside)  state_d = ST_RIGHT;
            else if (!rotate_n && rblock) state_d = ST_ROTATE;
            if (state_d inside {ST_DOWN, ST_LEFT, ST_RIGHT, ST_ROTATE}) begin
               act_d   = act_of(state_d);
               first_d = 1'b1;
               rep_clr = 1'b1;
            end
         end
         ST_DOWN, ST_LEFT, ST_RIGHT, ST_ROTATE: state_d = ST_HOLD;
         ST_LOCK:   state_d = ST_INIT;
         ST_HOLD: begin
            if (all_high)               state_d = ST_CHECK;
            else if (pend_q)            state_d = grav_st;
            else if (rep_wrap && rep_ok) begin
               state_d = act_state(act_q);
               first_d = 1'b0;
               rep_clr = 1'b1;
            end
         end
         default:   state_d = ST_CHECK;
      endcase
      pend_d = grav_wrap | (pend_q & !(state_d inside {ST_DOWN, ST_LOCK}));
   end

   // state, action, pending and first-repeat registers
   always_ff @(posedge SC_STATEMACHINEPIECE_CLOCK_50 or posedge SC_STATEMACHINEPIECE_RESET_InHigh)
      if (SC_STATEMACHINEPIECE_RESET_InHigh) begin
         state_q <= ST_RESET;
         act_q   <= ACT_DOWN;
         pend_q  <= 1'b0;
         first_q <= 1'b1;
      end else begin
         state_q <= state_d;
         act_q   <= act_d;
         pend_q  <= pend_d;
         first_q <= first_d;
      end

   sc_tickcounter #(.CNT_WIDTH(CNT_WIDTH)) u_grav (
      .clk   (SC_STATEMACHINEPIECE_CLOCK_50),
      .rst   (SC_STATEMACHINEPIECE_RESET_InHigh),
      .clr   (timers_off),
      .en    (!timers_off),
      .limit (GRAV_LIM),
      .wrap  (grav_wrap)
   );

   sc_tickcounter #(.CNT_WIDTH(CNT_WIDTH)) u_rep (
      .clk   (SC_STATEMACHINEPIECE_CLOCK_50),
      .rst   (SC_STATEMACHINEPIECE_RESET_InHigh),
      .clr   (rep_clr),
      .en    (state_q == ST_HOLD),
      .limit (first_q ? DLY_LIM : RATE_LIM),
      .wrap  (rep_wrap)
   );

   assign bus.SC_STATEMACHINEPIECE_clear_OutLow       = state_q != ST_INIT;
   assign bus.SC_STATEMACHINEPIECE_load0_OutLow       = state_q != ST_LOCK;
   assign bus.SC_STATEMACHINEPIECE_load1_OutLow       = state_q != ST_DOWN;
   assign bus.SC_STATEMACHINEPIECE_shiftselection_Out = state_q == ST_LEFT ? SHIFT_LEFT :
                                                        state_q == ST_RIGHT ? SHIFT_RIGHT : SHIFT_HOLD;
   assign bus.SC_STATEMACHINEPIECE_rotate_OutLow      = state_q != ST_ROTATE;

endmodule
